// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants (state encoding, parity types, prescale width)
// Used by both the transmitter and the receiver of the link.
package uart_pkg;
    localparam int PRESCALE_WIDTH = 6;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: per-bit prescale cycle counter with a one-cycle bit_done pulse
// Ports: clk, reset (async active-low), i_clear (frame accept), i_en (frame active),
//        i_prescale (latched cycles per bit, 0 acts as 1), o_bit_done (last cycle of a bit)
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_clear,
    input  logic                      i_en,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_bit_done
);
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [PRESCALE_WIDTH-1:0] w_last;

    assign w_last     = (i_prescale == '0) ? '0 : i_prescale - 1'b1;
    assign o_bit_done = i_en && (r_cnt == w_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_bit_done ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serializes a DATA_WIDTH word as start, data LSB-first, optional parity, stop
// Ports: clk, reset (async active-low), parity_enable, parity_type (0 even / 1 odd),
//        prescale (cycles per bit), parallel_data, data_valid (sampled while idle),
//        serial_data (line, idle high), busy (frame in progress)
// Build option: UART_TX_TWO_STOP_EN defined -> two stop bits instead of one.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [DATA_WIDTH-1:0]     parallel_data,
    input  logic                      data_valid,
    output logic                      serial_data,
    output logic                      busy
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
`ifdef UART_TX_TWO_STOP_EN
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(1);
`else
    localparam logic [BIT_W-1:0] LAST_STOP = '0;
`endif

    logic [2:0]                r_state;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic [BIT_W-1:0]          r_bit_cnt;
    logic                      r_par_en;
    logic                      r_parity;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      w_accept;
    logic                      w_bit_done;

    assign w_accept = (r_state == IDLE) && data_valid;

    uart_tx_bit_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_accept),
        .i_en       (r_state != IDLE),
        .i_prescale (r_prescale),
        .o_bit_done (w_bit_done)
    );

    // The bit counter also counts stop bits, so it is reused for the two-stop option.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_par_en    <= 1'b0;
            r_parity    <= 1'b0;
            r_prescale  <= '0;
            serial_data <= 1'b1;
            busy        <= 1'b0;
        end else if (w_accept) begin
            r_state     <= START;
            r_shift     <= parallel_data;
            r_par_en    <= parity_enable;
            r_parity    <= (^parallel_data) ^ (parity_type == PARITY_ODD);
            r_prescale  <= prescale;
            serial_data <= 1'b0;
            busy        <= 1'b1;
        end else if (w_bit_done) begin
            case (r_state)
                START: begin
                    r_state     <= DATA;
                    serial_data <= r_shift[0];
                    r_shift     <= r_shift >> 1;
                end
                DATA: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt   <= '0;
                        r_state     <= r_par_en ? PARITY : STOP;
                        serial_data <= r_par_en ? r_parity : 1'b1;
                    end else begin
                        r_bit_cnt   <= r_bit_cnt + 1'b1;
                        serial_data <= r_shift[0];
                        r_shift     <= r_shift >> 1;
                    end
                end
                PARITY: begin
                    r_state     <= STOP;
                    serial_data <= 1'b1;
                end
                STOP: begin
                    if (r_bit_cnt == LAST_STOP) begin
                        r_bit_cnt <= '0;
                        r_state   <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed checks of frame format, timing, busy handling and reset
`timescale 1ns/1ps
module tb_uart_transmitter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       parity_enable = 1'b0;
    logic       parity_type = 1'b0;
    logic       data_valid = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [7:0] parallel_data = 8'h00;
    logic       serial_data;
    logic       busy;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       cap_s [0:399];
    logic       cap_b [0:399];
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_N = 2;
`else
    localparam int STOP_N = 1;
`endif

    always #2.5 clk = ~clk;

    uart_transmitter #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .prescale      (prescale),
        .parallel_data (parallel_data),
        .data_valid    (data_valid),
        .serial_data   (serial_data),
        .busy          (busy)
    );

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_s[i] = serial_data;
            cap_b[i] = busy;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        @(negedge clk);
        parallel_data = d;
        parity_enable = pe;
        parity_type   = pt;
        prescale      = ps;
        data_valid    = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (serial_data !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b want 1", serial_data); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (serial_data !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: serial=%b busy=%b want serial=1 busy=0", serial_data, busy);
        end
    endtask

    // exp_bits holds the frame in transmission order, first bit at index nb-1.
    task automatic test_frame(input string name, input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] ps, input logic [10:0] exp_bits, input int nb,
                              input bit cfg_change);
        int p, fl, bad, busy_cnt, len, base;
        p  = (ps == 6'd0) ? 1 : int'(ps);
        fl = p * (nb - 1 + STOP_N);
        send(d, pe, pt, ps);
        if (cfg_change) begin
            parity_enable = ~pe;
            parity_type   = ~pt;
            prescale      = 6'd3;
            parallel_data = ~d;
        end
        capture(fl + 4);
        for (int k = 0; k < nb; k++) begin
            len  = (k == nb - 1) ? p * STOP_N : p;
            base = p * k;
            bad  = 0;
            for (int j = 0; j < len; j++)
                if (cap_s[base + j] !== exp_bits[nb - 1 - k]) bad++;
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL %s bit%0d: %0d of %0d samples differ, want %b", name, k, bad, len, exp_bits[nb - 1 - k]);
            end
        end
        busy_cnt = 0;
        for (int i = 0; i < fl + 4; i++)
            if (cap_b[i] === 1'b1) busy_cnt++;
        n_tests++;
        if (busy_cnt != fl || cap_b[fl - 1] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d cycles want %0d", name, busy_cnt, fl);
        end
        n_tests++;
        if (cap_b[fl] !== 1'b0 || cap_s[fl] !== 1'b1 || cap_s[fl + 3] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_after: busy=%b serial=%b/%b want 0 and 1/1", name, cap_b[fl], cap_s[fl], cap_s[fl + 3]);
        end
    endtask

    task automatic test_busy_handling;
        int fl, f2;
        fl = 8 * (9 + STOP_N);
        f2 = fl + 1;
        send(8'h81, 1'b0, 1'b0, 6'd8);
        for (int i = 0; i < f2 + 48; i++) begin
            @(negedge clk);
            cap_s[i] = serial_data;
            cap_b[i] = busy;
            if (i == 20) begin parallel_data = 8'h3C; data_valid = 1'b1; end
            if (i == 21) data_valid = 1'b0;
            if (i == 60) begin parallel_data = 8'hF0; data_valid = 1'b1; end
            if (i == f2) data_valid = 1'b0;
        end
        n_tests++;
        if (cap_s[4] !== 1'b0 || cap_s[12] !== 1'b1 || cap_s[28] !== 1'b0 || cap_s[68] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_drop_frame: bits s4=%b s12=%b s28=%b s68=%b want 0 1 0 1", cap_s[4], cap_s[12], cap_s[28], cap_s[68]);
        end
        n_tests++;
        if (cap_b[fl - 1] !== 1'b1 || cap_b[fl] !== 1'b0 || cap_s[fl] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_fall: busy=%b,%b serial=%b want 1,0 and 1", cap_b[fl - 1], cap_b[fl], cap_s[fl]);
        end
        n_tests++;
        if (cap_b[f2] !== 1'b1 || cap_s[f2] !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_start: busy=%b serial=%b want 1 and 0", cap_b[f2], cap_s[f2]);
        end
        n_tests++;
        if (cap_s[f2 + 28] !== 1'b0 || cap_s[f2 + 44] !== 1'b1) begin
            n_fail++;
            $display("FAIL back_to_back_data: bit2=%b bit4=%b want 0 and 1", cap_s[f2 + 28], cap_s[f2 + 44]);
        end
        repeat (fl) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || serial_data !== 1'b1) begin
            n_fail++;
            $display("FAIL no_queue: busy=%b serial=%b want 0 and 1", busy, serial_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        send(8'h6A, 1'b1, 1'b0, 6'd8);
        repeat (31) @(negedge clk);
        n_tests++;
        if (serial_data !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_state: serial=%b busy=%b want 0 and 1", serial_data, busy);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (serial_data !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_abort: serial=%b busy=%b want 1 and 0", serial_data, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_frame("even_6A", 8'h6A, 1'b1, 1'b0, 6'd8, 11'b00101011001, 11, 1'b1);
        test_frame("nopar_A5", 8'hA5, 1'b0, 1'b0, 6'd8, 11'b00101001011, 10, 1'b0);
        test_frame("odd_F7", 8'hF7, 1'b1, 1'b1, 6'd8, 11'b01110111101, 11, 1'b0);
        test_busy_handling;
        test_reset_mid_frame;
        test_frame("after_reset_55", 8'h55, 1'b0, 1'b0, 6'd8, 11'b00101010101, 10, 1'b0);
        test_frame("prescale0_A5", 8'hA5, 1'b0, 1'b0, 6'd0, 11'b00101001011, 10, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
